// File: rtl/fgyrus_fft_seq.sv
// Radix-2 DIT FFT butterfly sequencer: issues per-butterfly read/twiddle addresses
// over the masked channels, tracks in-flight butterflies in a tag FIFO, and emits
// write-back addresses as results return. A stage barrier holds off the next stage.
module fgyrus_fft_seq #(
    parameter int unsigned P_LOG2_N    = 7,
    parameter int unsigned P_NUM_CH    = 2,
    parameter int unsigned P_CH_W      = 1,
    parameter int unsigned P_STG_W     = 3,
    parameter int unsigned P_TAG_DEPTH = 8
) (
    input  logic                clk_ir,
    input  logic                rst_ih,
    input  logic                start_ih,
    input  logic [P_NUM_CH-1:0] ch_mask_id,
    input  logic                abort_ih,
    output logic                busy_oh,
    output logic                done_oh,
    output logic                err_oh,
    output logic [P_STG_W-1:0]  stage_od,
    output logic                rd_vld_oh,
    input  logic                rd_rdy_ih,
    output logic [P_CH_W-1:0]   rd_ch_od,
    output logic [P_LOG2_N-1:0] rd_addr_a_od,
    output logic [P_LOG2_N-1:0] rd_addr_b_od,
    output logic [P_LOG2_N-2:0] twdl_addr_od,
    input  logic                bfly_rdy_ih,
    output logic                wr_en_oh,
    output logic [P_CH_W-1:0]   wr_ch_od,
    output logic [P_LOG2_N-1:0] wr_addr_a_od,
    output logic [P_LOG2_N-1:0] wr_addr_b_od
);
    localparam int unsigned KW    = P_LOG2_N - 1;
    localparam int unsigned PTR_W = (P_TAG_DEPTH > 1) ? $clog2(P_TAG_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = P_CH_W + 2 * P_LOG2_N;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [P_NUM_CH-1:0] mask_q, mask_d;
    logic [P_CH_W-1:0]   ch_q, ch_d;
    logic [P_STG_W-1:0]  stage_q, stage_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                rd_vld_q, rd_vld_d;
    logic [P_CH_W-1:0]   rd_ch_q;
    logic [P_LOG2_N-1:0] rd_a_q, rd_b_q, rd_a_d, rd_b_d;
    logic [KW-1:0]       twdl_q, twdl_d;
    logic [TAG_W-1:0]    fifo_q [P_TAG_DEPTH];

    logic                push_c, pop_c, empty_c, flush_c;
    logic [P_CH_W-1:0]   low_ch_c, hi_ch_c;
    logic                hi_found_c;

    // A address: insert a zero at bit s of k (group index shifted past the half)
    function automatic logic [P_LOG2_N-1:0] addr_a_f(input logic [P_STG_W-1:0] s,
                                                     input logic [KW-1:0] k);
        logic [P_LOG2_N-1:0] kx;
        logic [P_LOG2_N-1:0] lo_msk;
        kx     = P_LOG2_N'(k);
        lo_msk = (P_LOG2_N'(1) << s) - P_LOG2_N'(1);
        return ((kx & ~lo_msk) << 1) | (kx & lo_msk);
    endfunction

    // Twiddle index: position within the group scaled to the N/2 twiddle table
    function automatic logic [KW-1:0] twdl_f(input logic [P_STG_W-1:0] s,
                                             input logic [KW-1:0] k);
        logic [KW-1:0] lo_msk;
        lo_msk = (KW'(1) << s) - KW'(1);
        return (k & lo_msk) << (P_STG_W'(KW) - s);
    endfunction

    assign empty_c  = (cnt_q == '0);
    assign push_c   = rd_vld_q & rd_rdy_ih;
    assign pop_c    = bfly_rdy_ih & ~empty_c;
    assign wr_en_oh = pop_c;
    assign {wr_ch_od, wr_addr_a_od, wr_addr_b_od} = fifo_q[rptr_q];

    // Lowest requested channel at start, and next higher latched channel after ch_q
    always_comb begin
        low_ch_c   = '0;
        hi_ch_c    = '0;
        hi_found_c = 1'b0;
        for (int i = int'(P_NUM_CH) - 1; i >= 0; i--) begin
            if (ch_mask_id[i]) low_ch_c = P_CH_W'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                hi_found_c = 1'b1;
                hi_ch_c    = P_CH_W'(i);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        stage_d = stage_q;
        k_d     = k_q;
        err_d   = err_q | (bfly_rdy_ih & empty_c);
        flush_c = 1'b0;
        if (abort_ih) begin
            state_d = S_IDLE;
            flush_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ih) begin
                        err_d = bfly_rdy_ih & empty_c;
                        if (ch_mask_id != '0) begin
                            mask_d  = ch_mask_id;
                            ch_d    = low_ch_c;
                            stage_d = '0;
                            k_d     = '0;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (push_c) begin
                        k_d = k_q + KW'(1);
                        if (k_q == {KW{1'b1}}) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (empty_c) begin
                        k_d = '0;
                        if (stage_q != P_STG_W'(P_LOG2_N - 1)) begin
                            stage_d = stage_q + P_STG_W'(1);
                            state_d = S_ISSUE;
                        end else if (hi_found_c) begin
                            ch_d    = hi_ch_c;
                            stage_d = '0;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        cnt_d    = flush_c ? '0 : (cnt_q + CNT_W'(push_c) - CNT_W'(pop_c));
        busy_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d   = (state_q == S_DONE) && !abort_ih;
        rd_vld_d = (state_d == S_ISSUE) && (cnt_d != CNT_W'(P_TAG_DEPTH));
        rd_a_d   = addr_a_f(stage_d, k_d);
        rd_b_d   = rd_a_d | (P_LOG2_N'(1) << stage_d);
        twdl_d   = twdl_f(stage_d, k_d);
    end

    // State, control and issue-output registers
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            stage_q  <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_ch_q  <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            twdl_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            stage_q  <= stage_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            wptr_q   <= flush_c ? '0 : (wptr_q + PTR_W'(push_c));
            rptr_q   <= flush_c ? '0 : (rptr_q + PTR_W'(pop_c));
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rd_vld_q <= rd_vld_d;
            rd_ch_q  <= ch_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            twdl_q   <= twdl_d;
        end
    end

    // Tag storage for in-flight butterflies (validity tracked by cnt_q)
    always_ff @(posedge clk_ir) begin
        if (push_c && !flush_c) fifo_q[wptr_q] <= {rd_ch_q, rd_a_q, rd_b_q};
    end

    assign busy_oh      = busy_q;
    assign done_oh      = done_q;
    assign err_oh       = err_q;
    assign stage_od     = stage_q;
    assign rd_vld_oh    = rd_vld_q;
    assign rd_ch_od     = rd_ch_q;
    assign rd_addr_a_od = rd_a_q;
    assign rd_addr_b_od = rd_b_q;
    assign twdl_addr_od = twdl_q;
endmodule

// File: tb/tb_fgyrus_fft_seq.sv
// Bench for fgyrus_fft_seq: randomized handshakes and butterfly latencies against
// a schedule model built from the butterfly addressing arithmetic.
module tb_fgyrus_fft_seq;
    localparam int unsigned LOG2_N = 3;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned STG_W  = 2;
    localparam int unsigned DEPTH  = 2;
    localparam int          NPTS   = 1 << LOG2_N;

    logic              clk_ir = 1'b0;
    logic              rst_ih = 1'b1;
    logic              start_ih = 1'b0;
    logic [NUM_CH-1:0] ch_mask_id = '0;
    logic              abort_ih = 1'b0;
    logic              busy_oh, done_oh, err_oh;
    logic [STG_W-1:0]  stage_od;
    logic              rd_vld_oh;
    logic              rd_rdy_ih = 1'b0;
    logic [CH_W-1:0]   rd_ch_od;
    logic [LOG2_N-1:0] rd_addr_a_od, rd_addr_b_od;
    logic [LOG2_N-2:0] twdl_addr_od;
    logic              bfly_rdy_ih = 1'b0;
    logic              wr_en_oh;
    logic [CH_W-1:0]   wr_ch_od;
    logic [LOG2_N-1:0] wr_addr_a_od, wr_addr_b_od;

    fgyrus_fft_seq #(
        .P_LOG2_N(LOG2_N), .P_NUM_CH(NUM_CH), .P_CH_W(CH_W),
        .P_STG_W(STG_W), .P_TAG_DEPTH(DEPTH)
    ) dut (
        .clk_ir(clk_ir), .rst_ih(rst_ih), .start_ih(start_ih), .ch_mask_id(ch_mask_id),
        .abort_ih(abort_ih), .busy_oh(busy_oh), .done_oh(done_oh), .err_oh(err_oh),
        .stage_od(stage_od), .rd_vld_oh(rd_vld_oh), .rd_rdy_ih(rd_rdy_ih),
        .rd_ch_od(rd_ch_od), .rd_addr_a_od(rd_addr_a_od), .rd_addr_b_od(rd_addr_b_od),
        .twdl_addr_od(twdl_addr_od), .bfly_rdy_ih(bfly_rdy_ih), .wr_en_oh(wr_en_oh),
        .wr_ch_od(wr_ch_od), .wr_addr_a_od(wr_addr_a_od), .wr_addr_b_od(wr_addr_b_od)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        int ch;
        int a;
        int b;
        int tw;
        int stg;
        int t_ret;
    } bfly_t;

    bfly_t exp_q[$];
    bfly_t infl_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected issue order: channels ascending, stages ascending, butterflies ascending
    task automatic build_sched(input logic [NUM_CH-1:0] mask);
        bfly_t it;
        exp_q.delete();
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            if (mask[ch]) begin
                for (int s = 0; s < int'(LOG2_N); s++) begin
                    for (int k = 0; k < NPTS / 2; k++) begin
                        int half, grp, pos;
                        half     = 1 << s;
                        grp      = k / half;
                        pos      = k % half;
                        it.ch    = ch;
                        it.stg   = s;
                        it.a     = grp * 2 * half + pos;
                        it.b     = it.a + half;
                        it.tw    = pos * (1 << (int'(LOG2_N) - 1 - s));
                        it.t_ret = 0;
                        exp_q.push_back(it);
                    end
                end
            end
        end
    endtask

    task automatic run_fft(input logic [NUM_CH-1:0] mask, input int lat_min, input int lat_max,
                           input int rdy_pct, input int abort_at);
        bfly_t it;
        int    issued, nwr, ndone, last_key, fin, aborted, total;
        build_sched(mask);
        infl_q.delete();
        total = exp_q.size();
        issued = 0; nwr = 0; ndone = 0; last_key = -1; fin = 0; aborted = 0;
        start_ih = 1'b1;
        ch_mask_id = mask;
        @(posedge clk_ir); #1;
        start_ih = 1'b0;
        exp_err = 0;
        for (int c = 0; c < 3000 && fin == 0; c++) begin
            bfly_rdy_ih = (infl_q.size() > 0) && (infl_q[0].t_ret <= c);
            rd_rdy_ih   = (int'($urandom_range(99)) < rdy_pct);
            #1;
            check_eq("err", int'(err_oh), exp_err);
            check_eq("wr_en", int'(wr_en_oh), int'(bfly_rdy_ih));
            if (exp_q.size() + infl_q.size() > 0) check_eq("busy", int'(busy_oh), 1);
            if (infl_q.size() >= int'(DEPTH)) check_eq("vld_when_full", int'(rd_vld_oh), 0);
            if (rd_vld_oh) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_issue", int'(rd_vld_oh), 0);
                end else begin
                    if (exp_q[0].stg * 16 + exp_q[0].ch != last_key)
                        check_eq("stage_barrier", infl_q.size(), 0);
                    if (rd_rdy_ih) begin
                        it = exp_q.pop_front();
                        check_eq("rd_ch", int'(rd_ch_od), it.ch);
                        check_eq("rd_a", int'(rd_addr_a_od), it.a);
                        check_eq("rd_b", int'(rd_addr_b_od), it.b);
                        check_eq("twdl", int'(twdl_addr_od), it.tw);
                        check_eq("stage", int'(stage_od), it.stg);
                        it.t_ret = c + int'($urandom_range(lat_max, lat_min));
                        if (infl_q.size() > 0 && it.t_ret < infl_q[$].t_ret)
                            it.t_ret = infl_q[$].t_ret;
                        infl_q.push_back(it);
                        last_key = it.stg * 16 + it.ch;
                        issued++;
                    end
                end
            end
            if (wr_en_oh && infl_q.size() > 0) begin
                it = infl_q.pop_front();
                check_eq("wr_ch", int'(wr_ch_od), it.ch);
                check_eq("wr_a", int'(wr_addr_a_od), it.a);
                check_eq("wr_b", int'(wr_addr_b_od), it.b);
                nwr++;
            end
            if (done_oh) begin
                check_eq("done_early", exp_q.size() + infl_q.size(), 0);
                ndone++;
                fin = 1;
            end
            if (abort_at >= 0 && issued >= abort_at && fin == 0) begin
                abort_ih    = 1'b1;
                bfly_rdy_ih = 1'b0;
                rd_rdy_ih   = 1'b0;
                aborted     = 1;
                fin         = 1;
            end
            @(posedge clk_ir); #1;
        end
        check_eq("timeout", fin, 1);
        bfly_rdy_ih = 1'b0;
        rd_rdy_ih   = 1'b0;
        if (aborted != 0) begin
            abort_ih = 1'b0;
            check_eq("abort_busy", int'(busy_oh), 0);
            check_eq("abort_vld", int'(rd_vld_oh), 0);
            exp_q.delete();
            infl_q.delete();
        end else begin
            check_eq("done_cnt", ndone, 1);
            check_eq("issue_cnt", issued, total);
            check_eq("write_cnt", nwr, total);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_ir); #1;
            check_eq("no_extra_done", int'(done_oh), 0);
            check_eq("idle_busy", int'(busy_oh), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_ir);
        #1;
        check_eq("rst_busy", int'(busy_oh), 0);
        check_eq("rst_done", int'(done_oh), 0);
        check_eq("rst_err", int'(err_oh), 0);
        check_eq("rst_vld", int'(rd_vld_oh), 0);
        check_eq("rst_wr_en", int'(wr_en_oh), 0);
        check_eq("rst_stage", int'(stage_od), 0);
        rst_ih = 1'b0;
        @(posedge clk_ir); #1;

        run_fft(4'b0001, 4, 4, 100, -1);
        run_fft(4'b0001, 10, 10, 100, -1);
        run_fft(4'b1010, 1, 10, 70, -1);

        // Empty mask: done two cycles after start, nothing issued
        start_ih   = 1'b1;
        ch_mask_id = '0;
        @(posedge clk_ir); #1;
        start_ih = 1'b0;
        check_eq("m0_done_c1", int'(done_oh), 0);
        check_eq("m0_busy", int'(busy_oh), 0);
        @(posedge clk_ir); #1;
        check_eq("m0_done_c2", int'(done_oh), 1);
        check_eq("m0_vld", int'(rd_vld_oh), 0);
        @(posedge clk_ir); #1;
        check_eq("m0_done_c3", int'(done_oh), 0);

        // Abort in stage 1, then a stray result sets the sticky error
        run_fft(4'b0001, 4, 4, 100, 6);
        bfly_rdy_ih = 1'b1;
        #1;
        check_eq("late_wr_en", int'(wr_en_oh), 0);
        @(posedge clk_ir); #1;
        bfly_rdy_ih = 1'b0;
        exp_err = 1;
        check_eq("late_err", int'(err_oh), exp_err);
        run_fft(4'b0101, 1, 6, 80, -1);

        for (int r = 0; r < 4; r++)
            run_fft(NUM_CH'($urandom_range(15, 1)), 1, 10, int'($urandom_range(100, 40)), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fgyrus_fft_seq.md
Name: fgyrus_fft_seq

Overview:
- Parametrised radix-2 DIT FFT butterfly sequencer: successor to the fixed 128-point, single-channel FFT control in Fgyrus.
- Generates per-butterfly read addresses and twiddle index for an N-point FFT, scheduled over multiple channels selected by a mask.
- Tracks in-flight butterflies in a tag FIFO, emits matching write-back addresses when butterfly results return, and enforces a RAW barrier between stages.
- Sits between the Fgyrus local-bus control and the butterfly wing / FFT cache RAMs. RAM contents are already in bit-reversed order.

Parameters:
P_LOG2_N, 7, log2 of FFT points (N = 2^P_LOG2_N, 3..10)
P_NUM_CH, 2, number of channels (1..8)
P_CH_W, 1, channel index width (>= clog2(P_NUM_CH), min 1)
P_STG_W, 3, stage counter width (>= clog2(P_LOG2_N))
P_TAG_DEPTH, 8, in-flight butterfly tag FIFO depth (power of 2, >= 2)

Ports:
clk_ir  in  1  clock
rst_ih  in  1  asynchronous reset, active-high
start_ih  in  1  1->start a run (sampled in IDLE only)
ch_mask_id  in  P_NUM_CH  channel enables, latched at start
abort_ih  in  1  1->terminate run
busy_oh  out  1  1->run in progress
done_oh  out  1  1-cycle pulse at run completion
err_oh  out  1  sticky: bfly_rdy_ih with no outstanding tag; cleared on accepted start
stage_od  out  P_STG_W  current stage
rd_vld_oh  out  1  butterfly issue valid
rd_rdy_ih  in  1  issue accepted when rd_vld_oh & rd_rdy_ih
rd_ch_od  out  P_CH_W  issue channel
rd_addr_a_od  out  P_LOG2_N  sample A address
rd_addr_b_od  out  P_LOG2_N  sample B address
twdl_addr_od  out  P_LOG2_N-1  twiddle index
bfly_rdy_ih  in  1  butterfly result valid (in issue order)
wr_en_oh  out  1  write-back enable
wr_ch_od  out  P_CH_W  write-back channel
wr_addr_a_od  out  P_LOG2_N  write-back address A
wr_addr_b_od  out  P_LOG2_N  write-back address B

Behaviour:

Reset:
- All outputs 0, FSM in IDLE, FIFO empty, outstanding = 0.

FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_ih with ch_mask_id != 0: latch mask, clear err_oh, select lowest set channel, stage = 0, k = 0, go to ISSUE.
  - start_ih with mask = 0: go to DONE without issuing.
- ISSUE:
  - rd_vld_oh = 1 unless outstanding == P_TAG_DEPTH.
  - Each accepted issue pushes {ch, addr_a, addr_b} into the FIFO and increments k.
  - Issue at k = N/2-1 goes to DRAIN.
- DRAIN:
  - rd_vld_oh = 0; wait for outstanding == 0.
  - If stage < P_LOG2_N-1: stage++, k = 0, go to ISSUE.
  - Else, if a higher masked channel remains: select it, stage = 0, k = 0, go to ISSUE.
  - Else go to DONE.
- DONE: done_oh = 1 for one cycle, then IDLE.
- busy_oh = 1 in ISSUE and DRAIN.
- start_ih outside IDLE is ignored.

Addressing, stage s, butterfly k:
- half = 2^s; grp = k >> s; pos = k & (half-1)
- addr_a = (grp << (s+1)) | pos
- addr_b = addr_a + half
- twdl = pos << (P_LOG2_N-1-s)
- All outputs are registered.

Write-back:
- Combinational from the FIFO head: wr_en_oh = bfly_rdy_ih & ~empty, with the head fields driven on wr_ch_od / wr_addr_a_od / wr_addr_b_od.
- Pop on wr_en_oh.
- Simultaneous push and pop leaves outstanding unchanged.
- bfly_rdy_ih while the FIFO is empty: no write, err_oh set.

Abort:
- abort_ih in any state forces IDLE next cycle, flushes the FIFO, sets outstanding = 0 and deasserts rd_vld_oh.
- No done_oh is generated.
- abort_ih has priority over start_ih in the same cycle.
- Result returns after an abort set err_oh.

Reset mid-run: immediate return to reset values.

Test Plan:
- P_LOG2_N=3, mask=1, rd_rdy=1, butterfly latency 4 -> 12 issues in this (a,b,tw) order, then exactly 12 writes with matching addresses and one done_oh:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Stage barrier: same setup -> first stage-1 issue (0,2) occurs strictly after the 4th stage-0 wr_en_oh; stage_od steps 0→1→2.
- P_TAG_DEPTH=2, butterfly latency 10 -> outstanding never exceeds 2; rd_vld_oh low while 2 are in flight; all 12 writes still occur.
- P_NUM_CH=4, mask=4'b1010 -> channel 1 fully (all stages), then channel 3; rd_ch_od never 0 or 2; single done_oh.
- mask=0 start -> done_oh two cycles after start, no rd_vld_oh; abort mid-stage-1 -> busy_oh low next cycle, no done_oh; a late bfly_rdy_ih sets err_oh; the next start clears it.
